// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-master memory port arbiter: data/address
// widths, write-strobe width, read-owner encodings and the owner helper.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif

package mem_port_arbiter_pkg;

    localparam int XLEN    = `XLEN;
    localparam int ADDR_W  = `ADDR_W;
    localparam int WSTRB_W = 4;

    // Which master owns the read data returning from memory this cycle.
    typedef enum logic [1:0] {
        OWN_IDLE  = 2'b00,
        OWN_RD_M0 = 2'b01,
        OWN_RD_M1 = 2'b10
    } owner_e;

    // A read grant hands the next cycle's memory data to that master;
    // writes and idle cycles leave nothing in flight.
    function automatic owner_e read_owner(input logic gnt0, input logic we0,
                                          input logic gnt1, input logic we1);
        owner_e own;
        own = OWN_IDLE;
        if (gnt0 && !we0) begin
            own = OWN_RD_M0;
        end else if (gnt1 && !we1) begin
            own = OWN_RD_M1;
        end
        return own;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-master (CPU m0, DMA m1) arbiter in front of a synchronous-read memory.
// m0 has fixed priority. Optional anti-starvation guard for m1 is enabled by
// defining ARB_STARVE_GUARD_EN; when undefined the starvation counter does not
// exist and m0 may starve m1 indefinitely.
//
// state     | meaning
// ----------+------------------------------------------------
// OWN_IDLE  | no read in flight, no rvalid this cycle
// OWN_RD_M0 | memory data this cycle belongs to m0 (m0_rvalid)
// OWN_RD_M1 | memory data this cycle belongs to m1 (m1_rvalid)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 m0_req,
    input  logic                 m0_we,
    input  logic [`ADDR_W-1:0]   m0_addr,
    input  logic [`XLEN-1:0]     m0_wdata,
    input  logic [WSTRB_W-1:0]   m0_wstrb,
    output logic                 m0_gnt,
    output logic                 m0_rvalid,
    output logic [`XLEN-1:0]     m0_rdata,

    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [`ADDR_W-1:0]   m1_addr,
    input  logic [`XLEN-1:0]     m1_wdata,
    input  logic [WSTRB_W-1:0]   m1_wstrb,
    output logic                 m1_gnt,
    output logic                 m1_rvalid,
    output logic [`XLEN-1:0]     m1_rdata,

    output logic                 mem_en,
    output logic                 mem_we,
    output logic [`ADDR_W-1:0]   mem_addr,
    output logic [`XLEN-1:0]     mem_wdata,
    output logic [WSTRB_W-1:0]   mem_wstrb,
    input  logic [`XLEN-1:0]     mem_rdata
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_limit_chk
        $error("mem_port_arbiter: STARVE_LIMIT must be within 1..255");
    end

    owner_e state_q, state_d;
    logic   m1_force;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] starve_q, starve_d;

    // m1 overrides m0 once it has been denied LIMIT cycles in a row.
    always_comb m1_force = m1_req && (starve_q == LIMIT);

    // Count consecutive denied m1 request cycles, saturating at LIMIT.
    always_comb begin
        starve_d = starve_q;
        if (!m1_req || m1_gnt) begin
            starve_d = 8'd0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 8'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= 8'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign m1_force = 1'b0;
`endif

    // Grant decision; gated by rst_n so grants vanish the moment reset asserts.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (rst_n) begin
            if (m1_force) begin
                m1_gnt = 1'b1;
            end else if (m0_req) begin
                m0_gnt = 1'b1;
            end else if (m1_req) begin
                m1_gnt = 1'b1;
            end
        end
    end

    // Forward the winner's access fields to memory; all zero when idle.
    always_comb begin
        mem_en    = m0_gnt | m1_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (m0_gnt) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_wstrb = m0_wstrb;
        end else if (m1_gnt) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_wstrb = m1_wstrb;
        end
    end

    // Read-owner next state: only a read grant leaves data in flight.
    always_comb begin
        state_d = OWN_IDLE;
        state_d = read_owner(m0_gnt, m0_we, m1_gnt, m1_we);
    end

    // Read-owner state register; reset drops any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OWN_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory data goes to both masters; rvalid alone says whose it is.
    always_comb begin
        m0_rvalid = (state_q == OWN_RD_M0);
        m1_rvalid = (state_q == OWN_RD_M1);
        m0_rdata  = mem_rdata;
        m1_rdata  = mem_rdata;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, meaning the number of consecutive denied m1 request cycles before m1 is force-granted (range 1..255).
REQ-002 SHALL have port clk  in  1  single system clock, rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports m0_req / m1_req  in  1  access request (m0 = CPU, m1 = DMA).
REQ-005 SHALL have ports m0_we / m1_we  in  1  1 = write, 0 = read.
REQ-006 SHALL have ports m0_addr / m1_addr  in  `ADDR_W  byte address, word aligned.
REQ-007 SHALL have ports m0_wdata / m1_wdata  in  `XLEN  write data.
REQ-008 SHALL have ports m0_wstrb / m1_wstrb  in  4  byte write enables.
REQ-009 SHALL have ports m0_gnt / m1_gnt  out  1  request accepted this cycle.
REQ-010 SHALL have ports m0_rvalid / m1_rvalid  out  1  read data valid.
REQ-011 SHALL have ports m0_rdata / m1_rdata  out  `XLEN  read data.
REQ-012 SHALL have ports mem_en, mem_we  out  1  memory access strobe and write select.
REQ-013 SHALL have ports mem_addr `ADDR_W, mem_wdata `XLEN, mem_wstrb 4  out  forwarded access fields.
REQ-014 SHALL have port mem_rdata  in  `XLEN  synchronous-read memory data, valid one cycle after mem_en with mem_we=0.

Function
REQ-015 SHALL grant at most one master per cycle; gnt is combinational from req and registered state.
REQ-016 SHALL drive mem_en=1 and forward the granted master's we/addr/wdata/wstrb in the grant cycle; mem_en=0 and mem_we=0 when no grant.
REQ-017 SHALL give m0 priority when both request, except as in REQ-025.
REQ-018 SHALL sustain one access per cycle; back-to-back grants to either master are legal.
REQ-019 SHALL implement a 3-state read-owner FSM: IDLE, RD_M0, RD_M1; next state = RD_Mx after a read grant to Mx, else IDLE.
REQ-020 SHALL assert mx_rvalid for exactly one cycle in state RD_Mx, with mx_rdata = mem_rdata; read latency gnt-to-rvalid is exactly 1 cycle.
REQ-021 SHALL produce no rvalid for writes; a write completes at its gnt cycle.
REQ-022 SHALL route mem_rdata to both mx_rdata buses; only the rvalid qualifies them.
REQ-023 Masters SHALL hold req and payload stable until gnt; dropping req before gnt withdraws the request with no side effect.
REQ-024 SHALL keep an 8-bit starvation counter: increment when m1_req && !m1_gnt (saturating at STARVE_LIMIT), clear on m1_gnt or !m1_req.

Configuration
REQ-025 With `ARB_STARVE_GUARD_EN defined, when the counter equals STARVE_LIMIT and m1_req=1, m1 SHALL win that cycle over m0; without it, the counter SHALL be absent and m0 has strict priority (m1 may starve).

Reset
REQ-026 On rst_n low, FSM SHALL go to IDLE, counter to 0, all gnt/rvalid/mem_en/mem_we to 0, immediately and asynchronously.
REQ-027 A read granted in the cycle before reset assertion SHALL yield no rvalid after reset release.
REQ-028 First grant SHALL be possible in the first rising edge cycle after rst_n deasserts.

Structure
REQ-029 Owner encodings (IDLE/RD_M0/RD_M1) and the wstrb width SHALL live in the shared defines/package alongside `XLEN and `ADDR_W.
REQ-030 SHALL be a single module; no sub-module is required.

Verification
REQ-031 m0 read 0x200 alone (mem holds 0xA0000000) -> m0_gnt same cycle, m0_rvalid next cycle, m0_rdata=0xA0000000.
REQ-032 m0 and m1 request together, guard disabled -> m0_gnt=1, m1_gnt=0 every cycle while m0_req held; m1 granted the first cycle m0_req=0.
REQ-033 Guard enabled, STARVE_LIMIT=8, m0_req held high continuously with m1_req high -> m1_gnt on 9th cycle of its request, counter cleared, m0 granted next cycle.
REQ-034 Alternating m1 write 0x300<=0x11 and m0 read 0x300 next cycle -> m0_rdata=0x11, no m1_rvalid.
REQ-035 m1 read granted, rst_n pulsed low before next edge -> m1_rvalid stays 0, all outputs 0 during reset.
REQ-036 Interleaved CPU counter writes at 0x500 and DMA 16-word copy 0x200->0x300 -> all words copied, counter strictly increasing.
